// File: rtl/snake_sequencer_if.sv
// snake_sequencer_if
// Groups the sequencer's link to the logic datapath and to the LED matrix.
//   master (sequencer side):
//     out logic_tick       tick request to the logic datapath
//     out no_update        with logic_tick: blink the head, no movement
//     out direction_state  current heading (UP=0, DOWN=1, LEFT=2, RIGHT=3)
//     out row_cathode      one-cold row enable
//     out column_anode     lit columns of the active row
//     in  logic_done       logic datapath finished its tick
//     in  game_end         collision flag, qualified by logic_done
//     in  led_array        frame buffer, row r = bits [r*COLS +: COLS]
//   slave (datapath / matrix side): the same signals, opposite directions.
interface snake_sequencer_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                   logic_tick;
    logic                   no_update;
    logic [1:0]             direction_state;
    logic [ROWS-1:0]        row_cathode;
    logic [COLS-1:0]        column_anode;
    logic                   logic_done;
    logic                   game_end;
    logic [ROWS*COLS-1:0]   led_array;

    modport master (
        output logic_tick, no_update, direction_state, row_cathode, column_anode,
        input  logic_done, game_end, led_array
    );

    modport slave (
        input  logic_tick, no_update, direction_state, row_cathode, column_anode,
        output logic_done, game_end, led_array
    );
endinterface

// File: rtl/snake_sequencer.sv
// snake_sequencer
// Frame sequencer for the snake game: state update, direction intake through a
// turn queue, logic datapath tick with timeout, and multiplexed LED display.
// Ports:
//   clka          sole clock, rising edge
//   restart_n     asynchronous active-low reset
//   direction_in  buttons, one-hot: UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000
//   pause_in      pause button, active high
//   bus           snake_sequencer_if.master (datapath handshake + LED matrix)
//   game_state    INIT=0, RUN=1, STOP=2, PAUSE=3
//   exec_state    UPDATE=0, CHECK=1, INPUT=2, WAIT_LOGIC=3, DISPLAY=4
//   timeout_err   sticky flag: the logic datapath failed to answer in time
module snake_sequencer #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int DISPLAY_CYCLES = 4,
    parameter int TURN_DEPTH     = 2,
    parameter int LOGIC_TIMEOUT  = 255
) (
    input  logic                    clka,
    input  logic                    restart_n,
    input  logic [3:0]              direction_in,
    input  logic                    pause_in,
    snake_sequencer_if.master       bus,
    output logic [1:0]              game_state,
    output logic [2:0]              exec_state,
    output logic                    timeout_err
);
    localparam int RW = $clog2(ROWS);
    localparam int SW = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
    localparam int TW = $clog2(LOGIC_TIMEOUT + 1);
    localparam int QW = $clog2(TURN_DEPTH + 1);

    localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
    localparam logic [SW-1:0]   SCAN_LAST = SW'(DISPLAY_CYCLES - 1);
    localparam logic [TW-1:0]   WAIT_LAST = TW'(LOGIC_TIMEOUT - 1);
    localparam logic [QW-1:0]   Q_FULL    = QW'(TURN_DEPTH);
    localparam logic [ROWS-1:0] ONE_ROW   = ROWS'(1);
    localparam logic [1:0]      DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        EX_UPDATE     = 3'd0,
        EX_CHECK      = 3'd1,
        EX_INPUT      = 3'd2,
        EX_WAIT_LOGIC = 3'd3,
        EX_DISPLAY    = 3'd4
    } exec_t;

    typedef enum logic [1:0] {
        GS_INIT  = 2'd0,
        GS_RUN   = 2'd1,
        GS_STOP  = 2'd2,
        GS_PAUSE = 2'd3
    } game_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return v inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    endfunction

    function automatic logic [1:0] encode_dir(input logic [3:0] v);
        case (v)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Opposite headings differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    function automatic logic turn_allowed(input logic [1:0] req, input logic [1:0] ref_dir);
        return (req != ref_dir) && (req != (ref_dir ^ 2'b01));
    endfunction

    // Control state
    exec_t              exec_q, exec_d;
    game_t              game_q, game_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         queue [TURN_DEPTH];
    logic [1:0]         queue_d [TURN_DEPTH];
    logic [QW-1:0]      q_cnt, q_cnt_d, cnt_after_pop;
    logic               start_pend, pause_pend, end_pend;
    logic               start_set, pause_set, end_set;
    logic [TW-1:0]      wait_cnt, wait_d;
    logic [RW-1:0]      row_cnt, row_d;
    logic [SW-1:0]      scan_cnt, scan_d;
    logic [3:0]         dir_prev;
    logic               pause_prev;
    logic               timeout_q, timeout_hit;

    // Display output registers
    logic [ROWS-1:0]    row_cathode_p0, row_cathode_d;
    logic [COLS-1:0]    column_anode_p0, column_anode_d;

    logic               press, pop, accept;
    logic [1:0]         press_dir, tail_dir;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) exec_q <= EX_UPDATE;
        else            exec_q <= exec_d;
    end

    always_comb begin
        exec_d      = exec_q;
        timeout_hit = 1'b0;
        case (exec_q)
            EX_UPDATE: exec_d = EX_CHECK;
            EX_CHECK:  exec_d = (game_q == GS_INIT || game_q == GS_PAUSE) ? EX_DISPLAY : EX_INPUT;
            EX_INPUT:  exec_d = EX_WAIT_LOGIC;
            EX_WAIT_LOGIC: begin
                if (bus.logic_done) begin
                    exec_d = EX_DISPLAY;
                end else if (wait_cnt == WAIT_LAST) begin
                    exec_d      = EX_DISPLAY;
                    timeout_hit = 1'b1;
                end
            end
            EX_DISPLAY: begin
                if (row_cnt == ROW_LAST && scan_cnt == SCAN_LAST) exec_d = EX_UPDATE;
            end
            default: exec_d = EX_UPDATE;
        endcase
    end

    always_comb begin
        press     = is_onehot4(direction_in) && (dir_prev == 4'd0);
        press_dir = encode_dir(direction_in);

        // A pop leaves the tail in place, and when the queue drains the popped
        // entry becomes direction_state, so the reference is the pre-pop tail.
        pop           = (exec_q == EX_CHECK) && (game_q == GS_RUN) && (q_cnt != '0);
        cnt_after_pop = q_cnt - QW'(pop);
        tail_dir      = dir_q;
        for (int i = 0; i < TURN_DEPTH; i++) begin
            if (q_cnt == QW'(i + 1)) tail_dir = queue[i];
        end
        accept = press && (game_q == GS_INIT || game_q == GS_RUN) &&
                 turn_allowed(press_dir, tail_dir) && (cnt_after_pop != Q_FULL);

        queue_d = queue;
        if (pop) begin
            for (int i = 0; i < TURN_DEPTH - 1; i++) queue_d[i] = queue[i + 1];
        end
        if (accept) begin
            for (int i = 0; i < TURN_DEPTH; i++) begin
                if (cnt_after_pop == QW'(i)) queue_d[i] = press_dir;
            end
        end
        q_cnt_d = cnt_after_pop + QW'(accept);
        dir_d   = pop ? queue[0] : dir_q;

        start_set = press && (game_q == GS_INIT);
        pause_set = pause_in && !pause_prev;
        end_set   = (exec_q == EX_WAIT_LOGIC) && bus.logic_done && bus.game_end;

        game_d = game_q;
        if (exec_q == EX_UPDATE) begin
            if (end_pend && game_q == GS_RUN)          game_d = GS_STOP;
            else if (pause_pend && game_q == GS_RUN)   game_d = GS_PAUSE;
            else if (pause_pend && game_q == GS_PAUSE) game_d = GS_RUN;
            else if (start_pend && game_q == GS_INIT)  game_d = GS_RUN;
        end

        wait_d = (exec_q == EX_WAIT_LOGIC && exec_d == EX_WAIT_LOGIC) ? wait_cnt + TW'(1) : '0;

        // row_cnt/scan_cnt index the row shown in the current DISPLAY cycle;
        // the output registers load from the next index so the lit row lines
        // up with exec_state and the matrix blanks as soon as DISPLAY ends.
        row_d  = '0;
        scan_d = '0;
        if (exec_q == EX_DISPLAY && exec_d == EX_DISPLAY) begin
            if (row_cnt == ROW_LAST) begin
                row_d  = '0;
                scan_d = scan_cnt + SW'(1);
            end else begin
                row_d  = row_cnt + RW'(1);
                scan_d = scan_cnt;
            end
        end

        row_cathode_d  = '1;
        column_anode_d = '0;
        if (exec_d == EX_DISPLAY) begin
            row_cathode_d  = ~(ONE_ROW << row_d);
            column_anode_d = bus.led_array[int'(row_d) * COLS +: COLS];
        end
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            game_q          <= GS_INIT;
            dir_q           <= DIR_RIGHT;
            for (int i = 0; i < TURN_DEPTH; i++) queue[i] <= '0;
            q_cnt           <= '0;
            start_pend      <= 1'b0;
            pause_pend      <= 1'b0;
            end_pend        <= 1'b0;
            wait_cnt        <= '0;
            row_cnt         <= '0;
            scan_cnt        <= '0;
            dir_prev        <= 4'd0;
            pause_prev      <= 1'b0;
            timeout_q       <= 1'b0;
            row_cathode_p0  <= '1;
            column_anode_p0 <= '0;
        end else begin
            game_q          <= game_d;
            dir_q           <= dir_d;
            queue           <= queue_d;
            q_cnt           <= q_cnt_d;
            // Old requests are consumed in UPDATE; an event arriving in that
            // same cycle is kept for the next frame.
            start_pend      <= (exec_q == EX_UPDATE) ? start_set : (start_pend | start_set);
            pause_pend      <= (exec_q == EX_UPDATE) ? pause_set : (pause_pend | pause_set);
            end_pend        <= (exec_q == EX_UPDATE) ? end_set   : (end_pend   | end_set);
            wait_cnt        <= wait_d;
            row_cnt         <= row_d;
            scan_cnt        <= scan_d;
            dir_prev        <= direction_in;
            pause_prev      <= pause_in;
            timeout_q       <= timeout_q | timeout_hit;
            row_cathode_p0  <= row_cathode_d;
            column_anode_p0 <= column_anode_d;
        end
    end

    assign game_state          = game_q;
    assign exec_state          = exec_q;
    assign timeout_err         = timeout_q;
    assign bus.direction_state = dir_q;
    assign bus.logic_tick      = (exec_q == EX_INPUT);
    assign bus.no_update       = (exec_q == EX_INPUT) && (game_q == GS_STOP);
    assign bus.row_cathode     = row_cathode_p0;
    assign bus.column_anode    = column_anode_p0;
endmodule

// File: tb/tb_snake_sequencer.sv
// tb_snake_sequencer
// Frame-level directed bench for snake_sequencer with default parameters.
module tb_snake_sequencer;
    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic       clka = 1'b0;
    logic       restart_n;
    logic [3:0] direction_in;
    logic       pause_in;
    logic [1:0] game_state;
    logic [2:0] exec_state;
    logic       timeout_err;

    snake_sequencer_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    snake_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .DISPLAY_CYCLES(4), .TURN_DEPTH(2), .LOGIC_TIMEOUT(255)
    ) dut (
        .clka(clka),
        .restart_n(restart_n),
        .direction_in(direction_in),
        .pause_in(pause_in),
        .bus(bus),
        .game_state(game_state),
        .exec_state(exec_state),
        .timeout_err(timeout_err)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic [15:0] presses;   // up to four button codes, top nibble first, 0 = none
        logic        pause;
        logic        done;
        logic        ge;
        logic [1:0]  exp_gs;
        int          exp_ticks;
        logic [1:0]  exp_dir;
        logic        exp_nu;
        int          exp_len;
        logic        exp_to;
    } frame_vec_t;

    int          checks = 0;
    int          errors = 0;
    int          len, ticks, disp_i;
    logic [1:0]  gs_chk, dir_tick;
    logic        nu_tick;
    logic [63:0] led_pat;
    frame_vec_t  tbl [9];
    frame_vec_t  tv  [3];

    function automatic frame_vec_t mk(input logic [15:0] pr, input logic pa, input logic dn,
                                      input logic ge, input logic [1:0] gs, input int tk,
                                      input logic [1:0] dr, input logic nu, input int ln,
                                      input logic to);
        frame_vec_t v;
        v.presses = pr; v.pause = pa; v.done = dn; v.ge = ge; v.exp_gs = gs;
        v.exp_ticks = tk; v.exp_dir = dr; v.exp_nu = nu; v.exp_len = ln; v.exp_to = to;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".game_state"}, 64'(game_state), 64'd0);
        check({tag, ".direction"}, 64'(bus.direction_state), 64'd3);
        check({tag, ".exec_state"}, 64'(exec_state), 64'd0);
        check({tag, ".logic_tick"}, 64'(bus.logic_tick), 64'd0);
        check({tag, ".no_update"}, 64'(bus.no_update), 64'd0);
        check({tag, ".row_cathode"}, 64'(bus.row_cathode), 64'hFF);
        check({tag, ".column_anode"}, 64'(bus.column_anode), 64'h00);
        check({tag, ".timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    // One clock; records frame statistics and checks the matrix every cycle.
    task automatic cyc(input string tag);
        logic [7:0] er;
        int r;
        @(posedge clka);
        #1;
        len++;
        if (exec_state == 3'd1) gs_chk = game_state;
        if (bus.logic_tick) begin
            ticks++;
            dir_tick = bus.direction_state;
            nu_tick  = bus.no_update;
        end
        if (exec_state == 3'd4) begin
            r  = disp_i % ROWS;
            er = ~(8'h01 << r);
            check($sformatf("%s.row%0d", tag, disp_i), 64'(bus.row_cathode), 64'(er));
            check($sformatf("%s.col%0d", tag, disp_i), 64'(bus.column_anode), 64'(led_pat[r*COLS +: COLS]));
            disp_i++;
        end else begin
            check($sformatf("%s.blank_row", tag), 64'(bus.row_cathode), 64'hFF);
            check($sformatf("%s.blank_col", tag), 64'(bus.column_anode), 64'h00);
        end
    endtask

    // Runs one frame starting in the UPDATE cycle and ending in the next UPDATE.
    task automatic run_frame(input frame_vec_t v, input string tag);
        logic [3:0] nib;
        len = 0; ticks = 0; disp_i = 0;
        gs_chk = 2'bxx; dir_tick = 2'bxx; nu_tick = 1'bx;
        bus.logic_done = v.done;
        bus.game_end   = v.ge;
        while (exec_state != 3'd4 && len < 400) cyc(tag);
        bus.game_end = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            nib = v.presses[k*4 +: 4];
            if (nib != 4'd0) begin
                direction_in = nib;
                cyc(tag);
                direction_in = 4'd0;
                cyc(tag);
            end
        end
        if (v.pause) begin
            pause_in = 1'b1;
            cyc(tag);
            pause_in = 1'b0;
            cyc(tag);
        end
        while (exec_state != 3'd0 && len < 400) cyc(tag);
        check({tag, ".game_state"}, 64'(gs_chk), 64'(v.exp_gs));
        check({tag, ".ticks"}, 64'(ticks), 64'(v.exp_ticks));
        if (v.exp_ticks != 0) begin
            check({tag, ".dir_at_tick"}, 64'(dir_tick), 64'(v.exp_dir));
            check({tag, ".no_update"}, 64'(nu_tick), 64'(v.exp_nu));
        end
        check({tag, ".frame_len"}, 64'(len), 64'(v.exp_len));
        check({tag, ".timeout_err"}, 64'(timeout_err), 64'(v.exp_to));
        bus.logic_done = 1'b1;
    endtask

    initial begin
        //            presses   pa  dn  ge  gs    tk dir   nu  len  to
        tbl[0] = mk(16'h1000, 1, 1, 0, 2'd0, 0, 2'd0, 0, 34, 0); // INIT: UP starts, pause discarded
        tbl[1] = mk(16'h8000, 0, 1, 0, 2'd1, 1, 2'd0, 0, 36, 0); // first tick heads UP
        tbl[2] = mk(16'h4142, 0, 1, 0, 2'd1, 1, 2'd3, 0, 36, 0); // LEFT rev, UP, LEFT, DOWN full
        tbl[3] = mk(16'h0000, 0, 1, 0, 2'd1, 1, 2'd0, 0, 36, 0); // pops UP
        tbl[4] = mk(16'h0000, 1, 1, 0, 2'd1, 1, 2'd2, 0, 36, 0); // pops LEFT, request pause
        tbl[5] = mk(16'h1000, 1, 1, 0, 2'd3, 0, 2'd0, 0, 34, 0); // PAUSE: press ignored, unpause
        tbl[6] = mk(16'h2000, 1, 1, 1, 2'd1, 1, 2'd2, 0, 36, 0); // collision + pause together
        tbl[7] = mk(16'h1000, 0, 1, 0, 2'd2, 1, 2'd2, 1, 36, 0); // STOP: blink, no pop
        tbl[8] = mk(16'h0000, 0, 1, 0, 2'd2, 1, 2'd2, 1, 36, 0);
        tv[0]  = mk(16'h1000, 0, 1, 0, 2'd0, 0, 2'd0, 0, 34, 0);
        tv[1]  = mk(16'h0000, 0, 0, 1, 2'd1, 1, 2'd0, 0, 290, 1); // 255-cycle timeout
        tv[2]  = mk(16'h0000, 0, 1, 0, 2'd1, 1, 2'd0, 0, 36, 1);  // no STOP, error sticky

        led_pat        = 64'h81C3_5AA5_0F3C_E718;
        bus.led_array  = led_pat;
        bus.logic_done = 1'b1;
        bus.game_end   = 1'b0;
        direction_in   = 4'd0;
        pause_in       = 1'b0;
        restart_n      = 1'b0;

        repeat (3) @(posedge clka);
        #1;
        check_reset_vals("reset");
        restart_n = 1'b1;

        for (int i = 0; i < 9; i++) run_frame(tbl[i], $sformatf("F%0d", i));

        // Asynchronous reset taken between clock edges.
        restart_n = 1'b0;
        #2;
        check_reset_vals("reset_async");
        @(posedge clka);
        #1;
        restart_n = 1'b1;

        for (int i = 0; i < 3; i++) run_frame(tv[i], $sformatf("T%0d", i));

        // Reset in the middle of DISPLAY must blank the matrix before the next edge.
        for (int n = 0; n < 50 && exec_state != 3'd4; n++) begin
            @(posedge clka);
            #1;
        end
        repeat (5) begin
            @(posedge clka);
            #1;
        end
        check("mid_display.exec_state", 64'(exec_state), 64'd4);
        restart_n = 1'b0;
        #2;
        check_reset_vals("reset_mid_display");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
